// File: rtl/droop_brake_ctrl.sv
`timescale 1ns/1ps
// droop_brake_ctrl
//   Supply-droop brake controller in front of the PLL feedback divider.
//   A droop alarm cuts the divide ratio by a clamped step. The cut is held
//   for HOLD_CYC cycles after the alarm clears, then ramped back to zero.
// Ports
//   refclk        reference clock, sole clock
//   resetn        asynchronous active-low reset
//   brake         droop alarm, asynchronous level input (2-flop synchronized)
//   divn          programmed divide ratio, signed, quasi-static
//   brake_state   0=BRAKES_OFF 1=BRAKES_APPLIED 2=BRAKES_HOLD 3=BRAKES_RELEASE
//   delta_n       signed divide-ratio reduction, registered
//   delta_f       delta_n*FSTEP, combinational from registered delta_n
//   brake_events  count of brake assertions, saturating
module droop_brake_ctrl #(
    parameter int STEP_N    = 8,
    parameter int MIN_DIVN  = 4,
    parameter int HOLD_CYC  = 64,
    parameter int RAMP_CYC  = 16,
    parameter int RAMP_STEP = 1,
    parameter int FSTEP     = 1000
) (
    input  logic               refclk,
    input  logic               resetn,
    input  logic               brake,
    input  logic signed [31:0] divn,
    output logic        [1:0]  brake_state,
    output logic signed [63:0] delta_n,
    output logic signed [63:0] delta_f,
    output logic        [15:0] brake_events
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned EVT_W = 16;

    typedef enum logic [1:0] {
        BRAKES_OFF     = 2'd0,
        BRAKES_APPLIED = 2'd1,
        BRAKES_HOLD    = 2'd2,
        BRAKES_RELEASE = 2'd3
    } brake_state_t;

    logic                    r_sync1;
    logic                    r_sync2;
    brake_state_t            r_state;
    brake_state_t            w_state_nxt;
    logic signed [63:0]      r_delta_n;
    logic signed [63:0]      w_delta_n_nxt;
    logic        [CNT_W-1:0] r_hold_cnt;
    logic        [CNT_W-1:0] w_hold_nxt;
    logic        [CNT_W-1:0] r_ramp_cnt;
    logic        [CNT_W-1:0] w_ramp_nxt;
    logic        [EVT_W-1:0] r_brake_events;
    logic        [EVT_W-1:0] w_events_nxt;
    logic        [EVT_W-1:0] w_events_inc;
    logic signed [63:0]      w_avail;
    logic signed [63:0]      w_step_eff;
    logic signed [63:0]      w_dec;
    logic signed [63:0]      w_dec_clamped;
    logic                    w_brake_s;

    assign w_brake_s = r_sync2;

    // Brake alarm synchronizer.
    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= brake;
            r_sync2 <= r_sync1;
        end
    end

    // Step clamped so the divider target never drops below MIN_DIVN.
    assign w_avail = 64'(divn) - 64'(MIN_DIVN);
    always_comb begin
        w_step_eff = w_avail;
        if (w_avail < 64'sd0) begin
            w_step_eff = 64'sd0;
        end else if (w_avail > 64'(STEP_N)) begin
            w_step_eff = 64'(STEP_N);
        end
    end

    assign w_dec         = r_delta_n - 64'(RAMP_STEP);
    assign w_dec_clamped = (w_dec < 64'sd0) ? 64'sd0 : w_dec;
    assign w_events_inc  = (r_brake_events == {EVT_W{1'b1}}) ? r_brake_events
                                                             : r_brake_events + EVT_W'(1);

    // Next-state logic; a synchronized brake always beats counter expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_delta_n_nxt = r_delta_n;
        w_hold_nxt    = r_hold_cnt;
        w_ramp_nxt    = r_ramp_cnt;
        w_events_nxt  = r_brake_events;
        case (r_state)
            BRAKES_OFF: begin
                if (w_brake_s) begin
                    w_state_nxt   = BRAKES_APPLIED;
                    w_delta_n_nxt = w_step_eff;
                    w_events_nxt  = w_events_inc;
                end
            end
            BRAKES_APPLIED: begin
                if (w_brake_s) begin
                    w_delta_n_nxt = w_step_eff;
                end else begin
                    w_state_nxt = BRAKES_HOLD;
                    w_hold_nxt  = CNT_W'(HOLD_CYC - 1);
                end
            end
            BRAKES_HOLD, BRAKES_RELEASE: begin
                if (w_brake_s) begin
                    w_state_nxt   = BRAKES_APPLIED;
                    w_delta_n_nxt = w_step_eff;
                    w_events_nxt  = w_events_inc;
                    w_hold_nxt    = CNT_W'(HOLD_CYC - 1);
                    w_ramp_nxt    = CNT_W'(RAMP_CYC - 1);
                end else if (r_state == BRAKES_HOLD) begin
                    if (r_hold_cnt == '0) begin
                        w_state_nxt = BRAKES_RELEASE;
                        w_ramp_nxt  = CNT_W'(RAMP_CYC - 1);
                    end else begin
                        w_hold_nxt = r_hold_cnt - CNT_W'(1);
                    end
                end else if (r_ramp_cnt == '0) begin
                    w_delta_n_nxt = w_dec_clamped;
                    w_ramp_nxt    = CNT_W'(RAMP_CYC - 1);
                    if (w_dec_clamped == 64'sd0) begin
                        w_state_nxt = BRAKES_OFF;
                    end
                end else begin
                    w_ramp_nxt = r_ramp_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = BRAKES_OFF;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= BRAKES_OFF;
            r_delta_n      <= 64'sd0;
            r_hold_cnt     <= '0;
            r_ramp_cnt     <= '0;
            r_brake_events <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_delta_n      <= w_delta_n_nxt;
            r_hold_cnt     <= w_hold_nxt;
            r_ramp_cnt     <= w_ramp_nxt;
            r_brake_events <= w_events_nxt;
        end
    end

    assign brake_state  = r_state;
    assign delta_n      = r_delta_n;
    assign delta_f      = r_delta_n * 64'(FSTEP);
    assign brake_events = r_brake_events;

endmodule

// File: tb/tb_droop_brake_ctrl.sv
`timescale 1ns/1ps
// Testbench for droop_brake_ctrl: directed stimulus pushes expected values
// tagged with the refclk edge they apply to; a monitor samples on the falling
// edge and compares against the queue head.
module tb_droop_brake_ctrl;

    localparam logic [1:0] S_OFF = 2'd0;
    localparam logic [1:0] S_APP = 2'd1;
    localparam logic [1:0] S_HLD = 2'd2;
    localparam logic [1:0] S_REL = 2'd3;

    logic               refclk = 1'b0;
    logic               resetn;
    logic               brake;
    logic signed [31:0] divn;
    logic        [1:0]  brake_state;
    logic signed [63:0] delta_n;
    logic signed [63:0] delta_f;
    logic        [15:0] brake_events;

    droop_brake_ctrl dut (
        .refclk       (refclk),
        .resetn       (resetn),
        .brake        (brake),
        .divn         (divn),
        .brake_state  (brake_state),
        .delta_n      (delta_n),
        .delta_f      (delta_f),
        .brake_events (brake_events)
    );

    always #5 refclk = ~refclk;

    int unsigned cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    typedef struct {
        int unsigned        cyc;
        string              name;
        logic [1:0]         st;
        logic signed [63:0] dn;
        logic signed [63:0] df;
        logic [15:0]        ev;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_at(input int unsigned c, input string nm, input logic [1:0] st,
                             input logic signed [63:0] dn, input logic signed [63:0] df,
                             input logic [15:0] ev);
        exp_t e;
        e.cyc = c; e.name = nm; e.st = st; e.dn = dn; e.df = df; e.ev = ev;
        sb_q.push_back(e);
    endtask

    // Advance to 1ns after refclk edge number e.
    task automatic goto(input int unsigned e);
        while (cyc < e) begin
            @(posedge refclk);
            #1;
        end
    endtask

    // Monitor: compare every entry whose edge has been reached.
    always @(negedge refclk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: edge %0d never sampled (now edge %0d)", e.name, e.cyc, cyc);
            end else if (brake_state !== e.st || delta_n !== e.dn ||
                         delta_f !== e.df || brake_events !== e.ev) begin
                n_fail++;
                $display("FAIL %s @edge %0d: got st=%0d dn=%0d df=%0d ev=%h, want st=%0d dn=%0d df=%0d ev=%h",
                         e.name, cyc, brake_state, delta_n, delta_f, brake_events,
                         e.st, e.dn, e.df, e.ev);
            end
        end
    end

    initial begin
        resetn = 1'b0;
        brake  = 1'b0;
        divn   = 32'sd100;

        expect_at(2, "reset_state", S_OFF, 0, 0, 16'h0000);
        goto(3);
        resetn = 1'b1;
        expect_at(53, "idle_50", S_OFF, 0, 0, 16'h0000);

        // Brake set after edge s is acted on at edge s+3.
        goto(59);
        brake = 1'b1;
        expect_at(61, "sync_latency", S_OFF, 0, 0, 16'h0000);
        expect_at(62, "apply", S_APP, 8, 8000, 16'h0001);

        goto(69);
        brake = 1'b0;
        expect_at(71,  "applied_until_sync", S_APP, 8, 8000, 16'h0001);
        expect_at(72,  "hold_entry",         S_HLD, 8, 8000, 16'h0001);
        expect_at(135, "hold_last",          S_HLD, 8, 8000, 16'h0001);
        expect_at(136, "release_entry",      S_REL, 8, 8000, 16'h0001);
        expect_at(151, "release_pre_dec",    S_REL, 8, 8000, 16'h0001);
        expect_at(152, "release_dec1",       S_REL, 7, 7000, 16'h0001);
        expect_at(263, "release_last",       S_REL, 1, 1000, 16'h0001);
        expect_at(264, "off_after_192",      S_OFF, 0, 0,    16'h0001);

        goto(269);
        brake = 1'b1;
        expect_at(272, "apply2", S_APP, 8, 8000, 16'h0002);
        goto(279);
        brake = 1'b0;
        expect_at(282, "hold2", S_HLD, 8, 8000, 16'h0002);

        // Re-brake while delta_n is 3 during release.
        goto(429);
        brake = 1'b1;
        expect_at(431, "release_at_3",       S_REL, 3, 3000, 16'h0002);
        expect_at(432, "rebrake_in_release", S_APP, 8, 8000, 16'h0003);
        goto(439);
        brake = 1'b0;
        expect_at(442, "hold3",          S_HLD, 8, 8000, 16'h0003);
        expect_at(505, "hold3_reloaded", S_HLD, 8, 8000, 16'h0003);
        expect_at(506, "release3",       S_REL, 8, 8000, 16'h0003);

        // divn changes ignored in release, tracked while applied.
        goto(509);
        divn  = 32'sd10;
        brake = 1'b1;
        expect_at(511, "divn_ignored_rel", S_REL, 8, 8000, 16'h0003);
        expect_at(512, "clamp_divn10",     S_APP, 6, 6000, 16'h0004);
        goto(520);
        divn = 32'sd3;
        expect_at(521, "divn3_zero", S_APP, 0, 0, 16'h0004);
        goto(525);
        divn = 32'sd12;
        expect_at(526, "divn12_full", S_APP, 8, 8000, 16'h0004);
        goto(530);
        divn = 32'sd11;
        expect_at(531, "divn11", S_APP, 7, 7000, 16'h0004);
        goto(535);
        divn = -32'sd5;
        expect_at(536, "divn_negative", S_APP, 0, 0, 16'h0004);
        goto(540);
        divn = 32'sd100;
        expect_at(541, "divn100", S_APP, 8, 8000, 16'h0004);

        // Asynchronous reset in the middle of hold.
        goto(549);
        brake = 1'b0;
        expect_at(552, "hold4", S_HLD, 8, 8000, 16'h0004);
        goto(560);
        resetn = 1'b0;
        expect_at(560, "async_reset", S_OFF, 0, 0, 16'h0000);
        goto(562);
        resetn = 1'b1;

        // Saturation of the event counter.
        goto(564);
        force dut.r_brake_events = 16'hFFFE;
        goto(565);
        release dut.r_brake_events;
        expect_at(567, "preset_fffe", S_OFF, 0, 0, 16'hFFFE);
        goto(569);
        brake = 1'b1;
        expect_at(572, "sat_brake1", S_APP, 8, 8000, 16'hFFFF);
        goto(574);
        brake = 1'b0;
        expect_at(577, "sat_hold1", S_HLD, 8, 8000, 16'hFFFF);
        goto(577);
        brake = 1'b1;
        expect_at(580, "sat_brake2", S_APP, 8, 8000, 16'hFFFF);
        goto(582);
        brake = 1'b0;
        expect_at(585, "sat_hold2", S_HLD, 8, 8000, 16'hFFFF);
        goto(585);
        brake = 1'b1;
        expect_at(588, "sat_brake3", S_APP, 8, 8000, 16'hFFFF);
        goto(595);
        brake = 1'b0;
        goto(600);

        // Bounded drain of anything still pending.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge refclk);
        end
        while (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: still pending at edge %0d, want edge %0d", sb_q[0].name, cyc, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
